// File: rtl/mult_result_stage.sv
// Result correction stage for a normal-number FP32 multiplier, feeding a 2-entry output FIFO.
// Optional sticky flag accumulation is enabled by defining MULT_STICKY_FLAGS_EN.
module mult_result_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic [31:0] product,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [2:0]  out_flags,
   output logic [2:0]  sticky_flags,
   input  logic        flags_clear
);

   logic [7:0]        ea, eb;
   logic              sign;
   logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic signed [9:0] s, e;
   logic              carry;
   logic [31:0]       res;
   logic [2:0]        flg;

   assign ea     = operand_a[30:23];
   assign eb     = operand_b[30:23];
   assign sign   = operand_a[31] ^ operand_b[31];
   assign nan_a  = (ea == 8'hFF) && (operand_a[22:0] != 23'd0);
   assign nan_b  = (eb == 8'hFF) && (operand_b[22:0] != 23'd0);
   assign inf_a  = (ea == 8'hFF) && (operand_a[22:0] == 23'd0);
   assign inf_b  = (eb == 8'hFF) && (operand_b[22:0] == 23'd0);
   assign zero_a = (ea == 8'd0);
   assign zero_b = (eb == 8'd0);

   // The multiplier's exponent field only differs from the biased sum when its
   // mantissa product normalised upward, so a mismatch means +1.
   assign s     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
   assign carry = (product[30:23] != s[7:0]);
   assign e     = s + $signed({9'd0, carry});

   always_comb begin
      res = product;
      flg = 3'b000;
      if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
         res = 32'h7FC0_0000;
         flg = 3'b100;
      end else if (inf_a || inf_b) begin
         res = {sign, 8'hFF, 23'd0};
      end else if (zero_a || zero_b) begin
         res = {sign, 31'd0};
      end else if (e >= 10'sd255) begin
         res = {sign, 8'hFF, 23'd0};
         flg = 3'b010;
      end else if (e <= 10'sd0) begin
         res = {sign, 31'd0};
         flg = 3'b001;
      end
   end

   logic [34:0] mem [2];
   logic        rd_ptr, wr_ptr;
   logic [1:0]  count;
   logic        push, pop;

   assign in_ready   = (count < 2'd2) && !rst;
   assign out_valid  = (count != 2'd0);
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign out_result = out_valid ? mem[rd_ptr][31:0]  : 32'd0;
   assign out_flags  = out_valid ? mem[rd_ptr][34:32] : 3'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {flg, res};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef MULT_STICKY_FLAGS_EN
   // A clear in the same cycle as a pop keeps only the popped entry's flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sticky_flags <= 3'd0;
      else if (pop)
         sticky_flags <= (flags_clear ? 3'd0 : sticky_flags) | out_flags;
      else if (flags_clear)
         sticky_flags <= 3'd0;
   end
`else
   logic unused_flags_clear;
   assign unused_flags_clear = flags_clear;
   assign sticky_flags       = 3'd0;
`endif

endmodule

// File: tb/tb_mult_result_stage.sv
// Directed self-checking bench for mult_result_stage; sticky expectations follow MULT_STICKY_FLAGS_EN.
module tb_mult_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] operand_a, operand_b, product;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_flags;
   logic [2:0]  sticky_flags;
   logic        flags_clear;

   int          checks = 0;
   int          errors = 0;
   logic [2:0]  exp_sticky = 3'd0;

   mult_result_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .operand_a(operand_a), .operand_b(operand_b), .product(product),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_flags(out_flags), .sticky_flags(sticky_flags), .flags_clear(flags_clear)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
      operand_a = a;
      operand_b = b;
      product   = p;
      in_valid  = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flags_clear = 1'b0;
      operand_a = '0; operand_b = '0; product = '0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0 ||
          out_flags !== 3'd0 || sticky_flags !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b out_result=%h out_flags=%b sticky=%b, want 0 0 0 0 0",
                  in_ready, out_valid, out_result, out_flags, sticky_flags);
      end
      step(); step();
      rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      set_in(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h4000_0000 || out_flags !== 3'b000) begin
         errors++;
         $display("FAIL basic_latency: valid=%b result=%h flags=%b, want 1 40000000 000",
                  out_valid, out_result, out_flags);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || out_result !== 32'd0 || out_flags !== 3'd0) begin
         errors++;
         $display("FAIL basic_drain: valid=%b result=%h flags=%b, want 0 0 0",
                  out_valid, out_result, out_flags);
      end
   endtask

   task automatic test_select();
      logic [31:0] ta [13];
      logic [31:0] tb [13];
      logic [31:0] tp [13];
      logic [31:0] tr [13];
      logic [2:0]  tf [13];
      ta = '{32'h7F00_0000, 32'h0080_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'hFF80_0000,
             32'h8000_0000, 32'h0040_0000, 32'h3FC0_0000, 32'h7F40_0000, 32'h1F80_0000,
             32'h1F80_0000, 32'h7F00_0000, 32'hBF80_0000};
      tb = '{32'h7F00_0000, 32'h0080_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000,
             32'h3F80_0000, 32'h7F80_0000, 32'h3FC0_0000, 32'h3FC0_0000, 32'h2000_0000,
             32'h2080_0000, 32'h3F80_0000, 32'h4000_0000};
      tp = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
             32'h0000_0000, 32'h0000_0000, 32'h4010_0000, 32'h7F90_0000, 32'h0000_0000,
             32'h0080_0000, 32'h7F00_0000, 32'hC000_0000};
      tr = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000,
             32'h8000_0000, 32'h7FC0_0000, 32'h4010_0000, 32'h7F80_0000, 32'h0000_0000,
             32'h0080_0000, 32'h7F00_0000, 32'hC000_0000};
      tf = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b000,
             3'b000, 3'b100, 3'b000, 3'b010, 3'b001,
             3'b000, 3'b000, 3'b000};
      out_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         set_in(ta[i], tb[i], tp[i]);
         step();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_result !== tr[i] || out_flags !== tf[i]) begin
            errors++;
            $display("FAIL select_%0d: valid=%b result=%h flags=%b, want 1 %h %b",
                     i, out_valid, out_result, out_flags, tr[i], tf[i]);
         end
         step();
`ifdef MULT_STICKY_FLAGS_EN
         exp_sticky = exp_sticky | tf[i];
`endif
         checks++;
         if (out_valid !== 1'b0 || sticky_flags !== exp_sticky) begin
            errors++;
            $display("FAIL select_pop_%0d: valid=%b sticky=%b, want 0 %b",
                     i, out_valid, sticky_flags, exp_sticky);
         end
      end
   endtask

   task automatic test_sticky();
      out_ready   = 1'b0;
      flags_clear = 1'b1;
      step();
      flags_clear = 1'b0;
      exp_sticky  = 3'd0;
      checks++;
      if (sticky_flags !== 3'd0) begin
         errors++;
         $display("FAIL sticky_clear: sticky=%b, want 000", sticky_flags);
      end
      // seed a flag, then buffer an underflow and clear in the cycle it pops
      set_in(32'h7F00_0000, 32'h7F00_0000, 32'h0);
      out_ready = 1'b1;
      step();
      set_in(32'h0080_0000, 32'h0080_0000, 32'h0);
      step();
      in_valid    = 1'b0;
      flags_clear = 1'b1;
      step();
      flags_clear = 1'b0;
`ifdef MULT_STICKY_FLAGS_EN
      exp_sticky = 3'b001;
`endif
      checks++;
      if (sticky_flags !== exp_sticky || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clear_pop: sticky=%b valid=%b, want %b 0",
                  sticky_flags, out_valid, exp_sticky);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      set_in(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
      step();
      checks++;
      if (out_result !== 32'h3F80_0000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_a: result=%h in_ready=%b, want 3f800000 1", out_result, in_ready);
      end
      set_in(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000);
      step();
      checks++;
      if (in_ready !== 1'b0 || out_result !== 32'h3F80_0000) begin
         errors++;
         $display("FAIL b2b_full: in_ready=%b result=%h, want 0 3f800000", in_ready, out_result);
      end
      set_in(32'h4040_0000, 32'h3F80_0000, 32'h4040_0000);
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h3F80_0000 || out_flags !== 3'd0) begin
         errors++;
         $display("FAIL b2b_hold: in_ready=%b valid=%b result=%h flags=%b, want 0 1 3f800000 000",
                  in_ready, out_valid, out_result, out_flags);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_result !== 32'h4000_0000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_b: result=%h in_ready=%b, want 40000000 1", out_result, in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h4040_0000) begin
         errors++;
         $display("FAIL b2b_c: valid=%b result=%h, want 1 40400000", out_valid, out_result);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      set_in(32'h7F00_0000, 32'h7F00_0000, 32'h0);
      step();
      set_in(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
      step();
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      exp_sticky = 3'd0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== 32'd0 || sticky_flags !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b in_ready=%b result=%h sticky=%b, want 0 0 0 000",
                  out_valid, in_ready, out_result, sticky_flags);
      end
      step();
      rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_release: in_ready=%b valid=%b, want 1 0", in_ready, out_valid);
      end
      out_ready = 1'b1;
      set_in(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h4080_0000 || out_flags !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid_next: valid=%b result=%h flags=%b, want 1 40800000 000",
                  out_valid, out_result, out_flags);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_select();
      test_sticky();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
